// File: rtl/regfile_ctrl.sv
// regfile_ctrl: command-driven initiator for an 8x16 register file.
//   Accepts WRITE/READ/MOVE/DUMP commands on a valid/ready port and sequences
//   the register file's write port and two read ports; read results return on
//   a valid/ready response port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op                         00 WRITE, 01 READ, 10 MOVE, 11 DUMP
//   cmd_dst/cmd_srcA/cmd_srcB      register indices
//   cmd_data                       write data
//   rsp_valid/rsp_ready            response handshake
//   rsp_a/rsp_b/rsp_idx/rsp_last   response payload
//   rf_*                           register file write port and read ports
// Build option: RF_DUMP_EN enables the DUMP sequencer (DLOAD/DRESP states and
//   the idx counter); without it op 11 is consumed as a NOP.
module regfile_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_srcA,
   input  logic [ADDR_W-1:0] cmd_srcB,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_a,
   output logic [DATA_W-1:0] rsp_b,
   output logic [ADDR_W-1:0] rsp_idx,
   output logic              rsp_last,
   output logic [DATA_W-1:0] rf_data_in,
   output logic [ADDR_W-1:0] rf_writenum,
   output logic [ADDR_W-1:0] rf_readnumA,
   output logic [ADDR_W-1:0] rf_readnumB,
   output logic              rf_write,
   input  logic [DATA_W-1:0] rf_data_outA,
   input  logic [DATA_W-1:0] rf_data_outB
);
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
`ifdef RF_DUMP_EN
   localparam logic [1:0] OP_DUMP  = 2'b11;
   typedef enum logic [2:0] {IDLE, EXEC, RESP, DLOAD, DRESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif
   state_t state, state_d;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] dst_q, srca_q, srcb_q;
   logic [DATA_W-1:0] data_q;
`ifdef RF_DUMP_EN
   logic [ADDR_W-1:0] idx, rsp_idx_q;
   logic              idx_last;
   assign idx_last = idx == '1;
   assign rsp_idx  = rsp_idx_q;
`else
   assign rsp_idx = '0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_comb begin
      state_d     = state;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_last    = 1'b0;
      rf_write    = 1'b0;
      rf_writenum = dst_q;
      rf_data_in  = data_q;
      rf_readnumA = srca_q;
      rf_readnumB = srcb_q;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            state_d   = cmd_valid ? EXEC : IDLE;
         end
         EXEC: begin
            rf_write   = (op_q == OP_WRITE) || (op_q == OP_MOVE);
            // MOVE writes back whatever read port A returns for srcA this cycle
            rf_data_in = (op_q == OP_MOVE) ? rf_data_outA : data_q;
`ifdef RF_DUMP_EN
            state_d = (op_q == OP_READ) ? RESP : (op_q == OP_DUMP) ? DLOAD : IDLE;
`else
            state_d = (op_q == OP_READ) ? RESP : IDLE;
`endif
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = 1'b1;
            state_d   = rsp_ready ? IDLE : RESP;
         end
`ifdef RF_DUMP_EN
         DLOAD: begin
            rf_readnumA = idx;
            state_d     = DRESP;
         end
         DRESP: begin
            rf_readnumA = idx;
            rsp_valid   = 1'b1;
            rsp_last    = idx_last;
            state_d     = rsp_ready ? (idx_last ? IDLE : DLOAD) : DRESP;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_q   <= '0;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         data_q <= '0;
         rsp_a  <= '0;
         rsp_b  <= '0;
`ifdef RF_DUMP_EN
         idx       <= '0;
         rsp_idx_q <= '0;
`endif
      end else begin
         if (state == IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            srca_q <= cmd_srcA;
            srcb_q <= cmd_srcB;
            data_q <= cmd_data;
         end
         if (state == EXEC && op_q == OP_READ) begin
            rsp_a <= rf_data_outA;
            rsp_b <= rf_data_outB;
`ifdef RF_DUMP_EN
            rsp_idx_q <= '0;
`endif
         end
`ifdef RF_DUMP_EN
         if (state == EXEC && op_q == OP_DUMP) idx <= '0;
         if (state == DLOAD) begin
            rsp_a     <= rf_data_outA;
            rsp_b     <= '0;
            rsp_idx_q <= idx;
         end
         if (state == DRESP && rsp_ready && !idx_last) idx <= idx + ADDR_W'(1);
`endif
      end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: self-checking bench for regfile_ctrl with a behavioural register file
module tb_regfile_ctrl;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
   localparam logic [1:0] OP_DUMP  = 2'b11;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [2:0]  cmd_dst = '0, cmd_srcA = '0, cmd_srcB = '0;
   logic [15:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_a, rsp_b;
   logic [2:0]  rsp_idx;
   logic        rsp_last;
   logic [15:0] rf_data_in;
   logic [2:0]  rf_writenum, rf_readnumA, rf_readnumB;
   logic        rf_write;
   logic [15:0] rf_data_outA, rf_data_outB;
   logic [15:0] rf [8];
   logic [15:0] model [8];
   int          wr_count = 0;
   logic [2:0]  last_wnum = '0;
   logic [15:0] last_wdata = '0;
   int          checks = 0;
   int          failures = 0;
   typedef struct {
      logic [1:0]  op;
      logic [2:0]  dst, sa, sb;
      logic [15:0] data, ea, eb;
   } vec_t;
   vec_t tbl [11];
   always #5 clk = ~clk;
   regfile_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
      .rsp_idx(rsp_idx), .rsp_last(rsp_last),
      .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_readnumA(rf_readnumA),
      .rf_readnumB(rf_readnumB), .rf_write(rf_write),
      .rf_data_outA(rf_data_outA), .rf_data_outB(rf_data_outB)
   );
   always @(posedge clk)
      if (rf_write) begin
         rf[rf_writenum] <= rf_data_in;
         wr_count        <= wr_count + 1;
         last_wnum       <= rf_writenum;
         last_wdata      <= rf_data_in;
      end
   assign rf_data_outA = rf[rf_readnumA];
   assign rf_data_outB = rf[rf_readnumB];
   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [15:0] d);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_srcA  = sa;
      cmd_srcB  = sb;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
      check("exec_busy", 64'(cmd_ready), 64'd0);
      if (op == OP_WRITE) model[dst] = d;
      if (op == OP_MOVE) model[dst] = model[sa];
      tick();
   endtask
   task automatic do_read(input logic [2:0] sa, input logic [2:0] sb, input int stall,
                          input logic [15:0] ea, input logic [15:0] eb, input string nm);
      send(OP_READ, 3'd0, sa, sb, 16'd0);
      check({nm, "_valid"}, 64'(rsp_valid), 64'd1);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({nm, "_hold"}, {rsp_valid, rsp_a, rsp_b, cmd_ready}, {1'b1, ea, eb, 1'b0});
      end
      check({nm, "_a"}, 64'(rsp_a), 64'(ea));
      check({nm, "_b"}, 64'(rsp_b), 64'(eb));
      check({nm, "_last_idx"}, {rsp_last, rsp_idx}, {1'b1, 3'd0});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({nm, "_idle"}, {cmd_ready, rsp_valid}, 2'b10);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      int w0, k, beats;
      int acc_cyc [8];
      for (int i = 0; i < 8; i++) model[i] = '0;
      tbl[0]  = '{OP_WRITE, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
      tbl[1]  = '{OP_WRITE, 3'd3, 3'd0, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
      tbl[2]  = '{OP_READ,  3'd0, 3'd3, 3'd0, 16'h0000, 16'hBEEF, 16'h0000};
      tbl[3]  = '{OP_WRITE, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h0000, 16'h0000};
      tbl[4]  = '{OP_MOVE,  3'd6, 3'd1, 3'd0, 16'h0000, 16'h0000, 16'h0000};
      tbl[5]  = '{OP_READ,  3'd0, 3'd6, 3'd1, 16'h0000, 16'h1234, 16'h1234};
      tbl[6]  = '{OP_WRITE, 3'd2, 3'd0, 3'd0, 16'h5A5A, 16'h0000, 16'h0000};
      tbl[7]  = '{OP_MOVE,  3'd2, 3'd2, 3'd0, 16'h0000, 16'h0000, 16'h0000};
      tbl[8]  = '{OP_READ,  3'd0, 3'd2, 3'd2, 16'h0000, 16'h5A5A, 16'h5A5A};
      tbl[9]  = '{OP_WRITE, 3'd7, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000};
      tbl[10] = '{OP_READ,  3'd0, 3'd7, 3'd3, 16'h0000, 16'hFFFF, 16'hBEEF};
      #3;
      check("reset_ctl", {cmd_ready, rsp_valid, rsp_last, rf_write}, 4'b1000);
      check("reset_rsp", {rsp_a, rsp_b, rsp_idx}, 35'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
         if (cmd_ready) begin
            cmd_dst    = 3'(k);
            cmd_data   = 16'(16'h1000 + k);
            model[k]   = 16'(16'h1000 + k);
            acc_cyc[k] = cyc;
            k++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      tick();
      check("b2b_count", 64'(k), 64'd8);
      for (int i = 1; i < 8; i++) check($sformatf("b2b_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);
      for (int i = 0; i < 8; i++)
         do_read(3'(i), 3'(7 - i), 0, 16'(16'h1000 + i), 16'(16'h1000 + 7 - i), $sformatf("b2b_rd%0d", i));
`ifdef RF_DUMP_EN
      send(OP_DUMP, 3'd0, 3'd0, 3'd0, 16'd0);
      beats = 0;
      for (int cyc = 0; cyc < 300 && beats < 8; cyc++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         if (rsp_valid && rsp_ready) begin
            check($sformatf("dump%0d_idx", beats), 64'(rsp_idx), 64'(beats));
            check($sformatf("dump%0d_a", beats), 64'(rsp_a), 64'(16'h1000 + beats));
            check($sformatf("dump%0d_b_last", beats), {rsp_b, rsp_last}, {16'h0000, beats == 7});
            beats++;
         end
         tick();
      end
      rsp_ready = 1'b0;
      check("dump_beats", 64'(beats), 64'd8);
      check("dump_done", {cmd_ready, rsp_valid}, 2'b10);
`else
      w0 = wr_count;
      send(OP_DUMP, 3'd4, 3'd5, 3'd6, 16'hDEAD);
      for (int i = 0; i < 4; i++) begin
         check("nop_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
         tick();
      end
      check("nop_no_write", 64'(wr_count - w0), 64'd0);
      do_read(3'd4, 3'd5, 0, 16'h1004, 16'h1005, "nop_rd");
`endif
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].op == OP_READ)
            do_read(tbl[i].sa, tbl[i].sb, 0, tbl[i].ea, tbl[i].eb, $sformatf("vec%0d", i));
         else begin
            w0 = wr_count;
            send(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].data);
            check($sformatf("vec%0d_wr", i), 64'(wr_count - w0), 64'd1);
            check($sformatf("vec%0d_wnum", i), 64'(last_wnum), 64'(tbl[i].dst));
            if (tbl[i].op == OP_WRITE) check($sformatf("vec%0d_wdata", i), 64'(last_wdata), 64'(tbl[i].data));
         end
      end
      do_read(3'd3, 3'd0, 5, 16'hBEEF, 16'h0000, "stall");
      send(OP_WRITE, 3'd5, 3'd0, 3'd0, 16'h0505);
      while (!cmd_ready) tick();
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_dst   = 3'd5;
      cmd_data  = 16'hAAAA;
      tick();
      cmd_valid = 1'b0;
      check("rst_exec_write", 64'(rf_write), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async", {cmd_ready, rsp_valid, rf_write}, 3'b100);
      tick();
      rst_n = 1'b1;
      tick();
      do_read(3'd5, 3'd5, 0, 16'h0505, 16'h0505, "rst_r5");
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [2:0]  dst, sa, sb;
         logic [15:0] d;
         op  = 2'($urandom_range(0, 2));
         dst = 3'($urandom_range(0, 7));
         sa  = 3'($urandom_range(0, 7));
         sb  = 3'($urandom_range(0, 7));
         d   = 16'($urandom);
         if (op == OP_READ)
            do_read(sa, sb, int'($urandom_range(0, 3)), model[sa], model[sb], "rnd_read");
         else begin
            w0 = wr_count;
            send(op, dst, sa, sb, d);
            check("rnd_wr", 64'(wr_count - w0), 64'd1);
         end
      end
      for (int i = 0; i < 8; i++) do_read(3'(i), 3'(i), 0, model[i], model[i], $sformatf("final_r%0d", i));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command-driven initiator for the 8×16 register file. It accepts register commands (WRITE, READ, MOVE, DUMP) over a valid/ready port and sequences the register file's write port and two read ports. Read results return on a valid/ready response port. The block is the sole driver of the register file's writenum/write/readnumA/readnumB/data_in inputs, which lets test and debug logic load, move and inspect registers without the datapath FSM.

## Interface
- DATA_W, 16, register and data width
- ADDR_W, 3, register index width; register count is 2**ADDR_W
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 WRITE, 01 READ, 10 MOVE, 11 DUMP
- cmd_dst  in  ADDR_W  destination register (WRITE, MOVE)
- cmd_srcA  in  ADDR_W  source A register (READ, MOVE)
- cmd_srcB  in  ADDR_W  source B register (READ)
- cmd_data  in  DATA_W  write data (WRITE)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_a, rsp_b  out  DATA_W  read data A / B
- rsp_idx  out  ADDR_W  register index of a DUMP beat, else 0
- rsp_last  out  1  final beat of a response (always 1 for READ)
- rf_data_in  out  DATA_W  register file write data
- rf_writenum, rf_readnumA, rf_readnumB  out  ADDR_W  register file indices
- rf_write  out  1  register file write enable
- rf_data_outA, rf_data_outB  in  DATA_W  register file read data (combinational)

## Operation
- States: IDLE, EXEC, RESP, DLOAD, DRESP.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, capture op/dst/srcA/srcB/data and go to EXEC. All other states: cmd_ready=0.
- EXEC lasts one cycle.
  - WRITE: rf_write=1, rf_writenum=dst, rf_data_in=data, then IDLE. No response.
  - READ: rf_readnumA=srcA, rf_readnumB=srcB; capture rf_data_outA/B into rsp_a/rsp_b, set rsp_idx=0, then RESP.
  - MOVE: rf_readnumA=srcA, rf_write=1, rf_writenum=dst, rf_data_in=rf_data_outA, then IDLE. No response. dst==srcA is legal and leaves the value unchanged.
  - DUMP: clear idx to 0, then DLOAD.
- RESP: rsp_valid=1, rsp_last=1. rsp_a, rsp_b and rsp_last hold stable until rsp_ready; on that handshake go to IDLE.
- DLOAD (one cycle): rf_readnumA=idx; capture rf_data_outA into rsp_a; rsp_b=0; rsp_idx=idx. Then DRESP.
- DRESP: rsp_valid=1; rsp_last=(idx==2**ADDR_W-1). On handshake: if last, go to IDLE; otherwise idx+1 and go to DLOAD.
- rf_write is asserted only in EXEC for WRITE or MOVE, never in any other state.
- rf_writenum defaults to the captured dst and rf_data_in to the captured data. rf_readnumA/B default to the captured srcA/srcB, except in DLOAD/DRESP, where rf_readnumA=idx.
- Reset (async, any state): state=IDLE; captured fields, idx, rsp_a, rsp_b and rsp_idx all 0; rsp_valid=0, rsp_last=0, rf_write=0, cmd_ready=1.
  - A command in flight is abandoned. No write occurs after rst_n falls.

## Timing
- Accept at edge E0; EXEC occupies the cycle after E0.
- WRITE/MOVE: the register updates at edge E1; cmd_ready=1 again after E1. Maximum rate is 1 command per 2 cycles.
- READ: data is captured at E1; rsp_valid=1 from E1 until the handshake edge. Latency from accept to response is 1 cycle.
- Read-after-write: a READ accepted after a WRITE always returns the new value, because the write completes before IDLE.
- DUMP: 2**ADDR_W beats, at least 2 cycles per beat; rsp_ready back-pressure stretches DRESP indefinitely.
- No output depends combinationally on cmd_valid or rsp_ready.
- rf_data_in depends combinationally on rf_data_outA, during MOVE only.

## Configuration
- RF_DUMP_EN defined: DUMP is implemented as described, using DLOAD/DRESP and the idx counter.
- RF_DUMP_EN undefined:
  - DLOAD, DRESP and idx are absent.
  - op 11 is accepted and consumed as a NOP (EXEC, then IDLE) with no response and no rf_write.
  - rsp_idx is tied to 0.

## Test plan
- After reset, WRITE dst=3, data=16'hBEEF, then READ srcA=3, srcB=0 -> rf_write pulses exactly one cycle with rf_writenum=3; response rsp_a=16'hBEEF, rsp_b=16'h0000 (R0 was loaded with 0 beforehand), rsp_last=1.
- WRITE R1=16'h1234, MOVE dst=6 srcA=1, READ 6/1 -> rsp_a=16'h1234, rsp_b=16'h1234; MOVE dst=srcA=2 leaves R2 unchanged.
- READ with rsp_ready held low for 5 cycles -> rsp_valid, rsp_a and rsp_b stable for all 5 cycles; cmd_ready=0 throughout; IDLE resumes after the handshake.
- RF_DUMP_EN: load Rk=16'h1000+k for k=0..7, issue DUMP with random rsp_ready -> 8 beats, rsp_idx 0..7 in order, rsp_a=16'h1000+idx, rsp_last only on idx=7. Without the macro, op 11 produces no response and no write.
- Assert rst_n low during EXEC of a WRITE R5=16'hAAAA -> R5 is unchanged, rsp_valid=0, cmd_ready=1 immediately.
- Back-to-back WRITEs with cmd_valid held high -> accepts occur every 2nd cycle; all 8 registers hold their written values on readback.
